// File: rtl/dmem_pkg.sv
// dmem_pkg: DMType access codes and controller state encoding.
package dmem_pkg;
  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF_S = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE_S = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
endpackage

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: req/ack data-memory bus between controller (master) and memory (slave).
interface dmem_access_ctrl_if #(parameter int ADDR_W = 32) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic              ack;
  logic [31:0]       rdata;
  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte enables, store lane shift, load shift/extend and misalign detect.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  type_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o,
  output logic        misalign_o
);
  logic        is_h, is_b, sgn;
  logic [31:0] sh;
  always_comb begin
    is_h       = type_i == DM_HALF_S || type_i == DM_HALF_U;
    is_b       = type_i == DM_BYTE_S || type_i == DM_BYTE_U;
    sgn        = type_i == DM_HALF_S || type_i == DM_BYTE_S;
    misalign_o = is_h ? off_i[0] : (!is_b && off_i != 2'b00);
    be_o       = is_b ? 4'b0001 << off_i : is_h ? 4'b0011 << off_i : 4'b1111;
    wdata_o    = wdata_i << {off_i, 3'b000};
    sh         = rdata_i >> {off_i, 3'b000};
    load_o     = is_b ? {{24{sgn & sh[7]}}, sh[7:0]} :
                 is_h ? {{16{sgn & sh[15]}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-memory sequencer with stall, load alignment and fault bubbles.
// Optional posted stores (no stall, single-entry buffer) with DMEM_POSTED_STORE_EN.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        dm_type,
  dmem_access_ctrl_if.master dm,
  output logic              stall,
  output logic              wb_bubble,
  output logic [DATA_W-1:0] load_data,
  output logic              misalign_exc,
  output logic              timeout_exc
);
`ifdef DMEM_POSTED_STORE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d, tout_q, tout_d;
  logic              abort_q, abort_d, posted_q, posted_d;
  logic [3:0]        be_q, be_d, be_c;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, wdata_c, ld_q, ld_d, ld_c;
  logic              acc, mis_c, stall_c, bub_c, mexc_c, post_c;
  dmem_lane_align u_align (
    .off_i      (mem_addr[1:0]),
    .type_i     (dm_type),
    .wdata_i    (mem_wdata),
    .rdata_i    (dm.rdata),
    .be_o       (be_c),
    .wdata_o    (wdata_c),
    .load_o     (ld_c),
    .misalign_o (mis_c)
  );
  assign acc = mem_valid & (mem_read | mem_write);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ld_d     = ld_q;
    tout_d   = 1'b0;
    abort_d  = abort_q;
    posted_d = posted_q;
    stall_c  = 1'b0;
    bub_c    = 1'b0;
    mexc_c   = 1'b0;
    post_c   = POSTED & mem_write;
    case (state_q)
      IDLE: begin
        if (acc && mis_c) begin
          mexc_c = 1'b1;
          bub_c  = 1'b1;
        end else if (acc) begin
          stall_c  = !post_c;
          req_d    = 1'b1;
          we_d     = mem_write;
          be_d     = be_c;
          addr_d   = {mem_addr[ADDR_W-1:2], 2'b00};
          wdata_d  = wdata_c;
          cnt_d    = '0;
          posted_d = post_c;
          state_d  = REQ;
        end
      end
      REQ: begin
        // a posted store only holds the pipeline once another access queues behind it
        stall_c = !posted_q || acc;
        if (dm.ack) begin
          req_d    = 1'b0;
          ld_d     = (mem_read && !posted_q) ? ld_c : ld_q;
          posted_d = 1'b0;
          state_d  = posted_q ? IDLE : RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          req_d    = 1'b0;
          tout_d   = 1'b1;
          abort_d  = !posted_q;
          posted_d = 1'b0;
          state_d  = posted_q ? IDLE : RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        bub_c   = abort_q;
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ld_q     <= '0;
      tout_q   <= 1'b0;
      abort_q  <= 1'b0;
      posted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ld_q     <= ld_d;
      tout_q   <= tout_d;
      abort_q  <= abort_d;
      posted_q <= posted_d;
    end
  end
  assign dm.req       = req_q;
  assign dm.we        = we_q;
  assign dm.be        = be_q;
  assign dm.addr      = addr_q;
  assign dm.wdata     = wdata_q;
  assign load_data    = ld_q;
  assign timeout_exc  = tout_q;
  assign stall        = stall_c & !rst;
  assign wb_bubble    = bub_c & !rst;
  assign misalign_exc = mexc_c & !rst;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed and randomized accesses checked against an arithmetic memory-access model.
module tb_dmem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [2:0]  dm_type = '0;
  logic        stall, wb_bubble, misalign_exc, timeout_exc;
  logic [31:0] load_data;
  int          nchk = 0, nerr = 0;
  logic [31:0] exp_ld = '0;

  dmem_access_ctrl_if #(.ADDR_W(32)) dm ();

  dmem_access_ctrl #(.TIMEOUT_CYCLES(16), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .dm_type(dm_type), .dm(dm),
    .stall(stall), .wb_bubble(wb_bubble), .load_data(load_data),
    .misalign_exc(misalign_exc), .timeout_exc(timeout_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int m_size(input logic [2:0] ty);
    return (ty == 3 || ty == 4) ? 1 : (ty == 1 || ty == 2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input int off, input logic [2:0] ty);
    longint v, span;
    span = longint'(1) << (8 * m_size(ty));
    v = (longint'(rd) >> (8 * off)) % span;
    if ((ty == 1 || ty == 3) && v >= span / 2) v -= span;
    return v[31:0];
  endfunction

  // one access through the pipeline; dly<0 means memory never acks
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] ty, input int dly, input logic [31:0] rdat);
    int    st = 0, rq = 0, off, sz;
    bit    done = 0, acc, mis;
    longint wsh;
    sz  = m_size(ty);
    off = int'(a % 4);
    acc = rd | wr;
    mis = acc && (off % sz) != 0;
    wsh = longint'(wd) << (8 * off);
    mem_valid = 1'b1; mem_read = rd; mem_write = wr;
    mem_addr = a; mem_wdata = wd; dm_type = ty;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      dm.ack = 1'b0;
      if (dm.req) begin
        if (rq == 0) begin
          chk("req_addr", dm.addr, a & 32'hFFFF_FFFC);
          chk("req_be", {28'd0, dm.be}, ((32'd1 << sz) - 1) << off);
          chk("req_we", {31'd0, dm.we}, {31'd0, wr});
          if (wr) chk("req_wdata", dm.wdata, wsh[31:0]);
        end
        if (rq == dly) begin
          dm.ack = 1'b1;
          dm.rdata = rdat;
        end
        rq++;
      end
      if (stall) st++;
      else begin
        done = 1;
        if (acc && !mis && rd && dly >= 0) exp_ld = m_load(rdat, off, ty);
        chk("resp_bubble", {31'd0, wb_bubble}, {31'd0, mis || (acc && dly < 0)});
        chk("resp_misalign", {31'd0, misalign_exc}, {31'd0, mis});
        chk("resp_timeout", {31'd0, timeout_exc}, {31'd0, acc && !mis && dly < 0});
        chk("resp_load", load_data, exp_ld);
      end
    end
    chk("resp_reached", {31'd0, done}, 32'd1);
    chk("stall_cycles", st, (!acc || mis) ? 0 : (dly < 0) ? 17 : dly + 2);
    chk("req_cycles", rq, (!acc || mis) ? 0 : (dly < 0) ? 16 : dly + 1);
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; dm.ack = 1'b0;
    @(negedge clk);
    chk("idle_stall", {31'd0, stall}, 32'd0);
    chk("idle_req", {31'd0, dm.req}, 32'd0);
    chk("idle_pulses", {29'd0, wb_bubble, misalign_exc, timeout_exc}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    dm.ack = 1'b0;
    dm.rdata = '0;
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_bubble", {31'd0, wb_bubble}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outs", {28'd0, dm.req, dm.we, misalign_exc, timeout_exc}, 32'd0);
    chk("rst_be", {28'd0, dm.be}, 32'd0);
    chk("rst_addr", dm.addr, 32'd0);
    chk("rst_wdata", dm.wdata, 32'd0);
    chk("rst_load", load_data, 32'd0);
    @(posedge clk); #1;

    access(1, 0, 32'h100, 32'h0, 3'b000, 0, 32'hDEADBEEF);
    chk("lw_value", load_data, 32'hDEADBEEF);
    access(1, 0, 32'h103, 32'h0, 3'b011, 2, 32'h80112233);
    chk("lb_value", load_data, 32'hFFFFFF80);
    access(1, 0, 32'h103, 32'h0, 3'b100, 1, 32'h80112233);
    chk("lbu_value", load_data, 32'h00000080);
    access(0, 1, 32'h202, 32'h0000ABCD, 3'b001, 0, 32'h0);
    chk("sh_keeps_load", load_data, 32'h00000080);
    access(1, 0, 32'h101, 32'h0, 3'b000, 0, 32'h12345678);
    access(1, 0, 32'h104, 32'h0, 3'b000, -1, 32'h0);
    access(1, 0, 32'h0FE, 32'h0, 3'b001, 3, 32'h8001_7FFF);
    chk("lh_value", load_data, 32'hFFFF8001);

    // stray ack with no outstanding request must be ignored
    dm.ack = 1'b1; dm.rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("stray_ack_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    dm.ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_load", load_data, exp_ld);
    chk("stray_ack_req", {31'd0, dm.req}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 4);
      access(op >= 2, op == 1, $urandom, $urandom, 3'($urandom_range(0, 7)),
             ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5)), $urandom);
    end

    mem_valid = 1'b1; mem_read = 1'b1; mem_addr = 32'h300; dm_type = 3'b000;
    repeat (4) @(posedge clk);
    #1;
    chk("midreq_req", {31'd0, dm.req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midreq_rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("midreq_outs", {28'd0, dm.req, dm.we, misalign_exc, timeout_exc}, 32'd0);
    chk("midreq_be", {28'd0, dm.be}, 32'd0);
    chk("midreq_addr", dm.addr, 32'd0);
    chk("midreq_load", load_data, 32'd0);
    mem_valid = 1'b0; mem_read = 1'b0;
    rst = 1'b0;
    exp_ld = '0;
    @(posedge clk); #1;
    access(1, 0, 32'h400, 32'h0, 3'b010, 0, 32'h1234_F00D);
    chk("lhu_value", load_data, 32'h0000F00D);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
